// File: rtl/layer_output_collector.sv
// layer_output_collector
//   Collects the serial activation stream of a fully-connected layer into
//   double-buffered vector banks. Each completed vector is presented in
//   parallel together with its maximum word and the index of that maximum.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   s_valid    upstream word valid
//   s_ready    a word can be accepted this cycle
//   data_in    upstream signed word
//   v_valid    a completed vector is presented
//   v_ready    downstream accepts the presented vector
//   v_data     packed vector, word k at [k*T +: T], word 0 received first
//   v_max      largest word of the presented vector
//   v_argmax   index of v_max, lowest index on ties
//   vec_count  vectors delivered downstream, modulo 256
module layer_output_collector #(
  parameter int M    = 8,
  parameter int T    = 16,
  parameter int LOGM = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                v_valid,
  input  logic                v_ready,
  output logic [M*T-1:0]      v_data,
  output logic signed [T-1:0] v_max,
  output logic [LOGM-1:0]     v_argmax,
  output logic [7:0]          vec_count
);

  localparam logic [LOGM-1:0] LAST = LOGM'(M - 1);

  logic signed [T-1:0] bank_mem [2][M];
  logic signed [T-1:0] bank_max [2];
  logic [LOGM-1:0]     bank_arg [2];

  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [LOGM-1:0]     word_idx;
  logic signed [T-1:0] run_max;
  logic [LOGM-1:0]     run_idx;

  logic                beat;
  logic                last_beat;
  logic                deliver;
  logic                take;
  logic signed [T-1:0] max_next;
  logic [LOGM-1:0]     idx_next;
  logic [1:0]          full_next;

  // The first word of a vector always seeds the running max; later words
  // replace it only when strictly larger, so ties keep the lower index.
  function automatic logic take_new(input logic                first,
                                    input logic signed [T-1:0] cand,
                                    input logic signed [T-1:0] cur);
    return first || (cand > cur);
  endfunction

  // Both handshake qualifiers depend only on registered flags.
  assign s_ready   = !reset && !full[wr_bank];
  assign v_valid   = full[rd_bank];
  assign beat      = s_valid && s_ready;
  assign last_beat = beat && (word_idx == LAST);
  assign deliver   = v_valid && v_ready;

  always_comb begin
    take     = take_new(word_idx == '0, data_in, run_max);
    max_next = take ? data_in : run_max;
    idx_next = take ? word_idx : run_idx;
  end

  // Completion and delivery always address different banks, so both
  // updates can apply in the same cycle.
  always_comb begin
    full_next = full;
    if (last_beat) full_next[wr_bank] = 1'b1;
    if (deliver)   full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      word_idx  <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      vec_count <= '0;
    end else begin
      full <= full_next;
      if (beat) begin
        run_max <= max_next;
        run_idx <= idx_next;
        if (last_beat) begin
          wr_bank  <= !wr_bank;
          word_idx <= '0;
        end else begin
          word_idx <= word_idx + LOGM'(1);
        end
      end
      if (deliver) begin
        rd_bank   <= !rd_bank;
        vec_count <= vec_count + 8'd1;
      end
    end
  end

  // Bank contents carry no reset; validity is tracked solely by full.
  always_ff @(posedge clk) begin
    if (beat) begin
      bank_mem[wr_bank][word_idx] <= data_in;
    end
    if (last_beat) begin
      bank_max[wr_bank] <= max_next;
      bank_arg[wr_bank] <= idx_next;
    end
  end

  always_comb begin
    v_data = '0;
    for (int k = 0; k < M; k++) begin
      v_data[k*T +: T] = bank_mem[rd_bank][k];
    end
    v_max    = bank_max[rd_bank];
    v_argmax = bank_arg[rd_bank];
  end

endmodule

// File: tb/tb_layer_output_collector.sv
// tb_layer_output_collector
//   Directed stimulus for layer_output_collector. Expected vectors are queued
//   when their words are issued; a monitor pops and compares each vector the
//   DUT delivers.
module tb_layer_output_collector;

  logic               clk;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] data_in;
  logic               v_valid;
  logic               v_ready;
  logic [127:0]       v_data;
  logic signed [15:0] v_max;
  logic [2:0]         v_argmax;
  logic [7:0]         vec_count;

  layer_output_collector #(.M(8), .T(16), .LOGM(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .data_in   (data_in),
    .v_valid   (v_valid),
    .v_ready   (v_ready),
    .v_data    (v_data),
    .v_max     (v_max),
    .v_argmax  (v_argmax),
    .vec_count (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]       data;
    logic signed [15:0] mx;
    logic [2:0]         am;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] mon_cnt = 8'd0;
  bit   watch_sready = 1'b0;
  int   sready_drops = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic logic [127:0] mk(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {a7[15:0], a6[15:0], a5[15:0], a4[15:0], a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  // Monitor: compares every delivered vector against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (watch_sready && !s_ready) sready_drops++;
      if (reset) begin
        mon_cnt = 8'd0;
      end else if (v_valid && v_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vector", {127'd0, v_valid}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("v_data", v_data, e.data);
          chk("v_max", v_max, e.mx);
          chk("v_argmax", {125'd0, v_argmax}, {125'd0, e.am});
          chk("vec_count_pre", {120'd0, vec_count}, {120'd0, mon_cnt});
        end
        mon_cnt = mon_cnt + 8'd1;
      end
    end
  end

  // All tasks below start and end on a falling edge.
  task automatic send(input logic signed [15:0] w);
    int n;
    n = 0;
    s_valid = 1'b1;
    data_in = w;
    #1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("send_timeout", {127'd0, s_ready}, 128'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [127:0] d, input logic signed [15:0] mx,
                         input logic [2:0] am, input int gap, input bit push);
    exp_t e;
    if (push) begin
      e.data = d; e.mx = mx; e.am = am;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      send(d[k*16 +: 16]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("s_ready_in_reset", {127'd0, s_ready}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_v_valid", {127'd0, v_valid}, 128'd0);
    chk("rst_vec_count", {120'd0, vec_count}, 128'd0);
    chk("rst_s_ready", {127'd0, s_ready}, 128'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] snap;
    logic [127:0] d;
    int n;
    int p;
    reset = 1'b1; s_valid = 1'b0; v_ready = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single vector, tie resolved to lower index.
    v_ready = 1'b1;
    run_vec(mk(5, -3, 12, 7, 12, 0, -20, 1), 16'sd12, 3'd2, 0, 1'b1);
    chk("s1_valid_rise", {127'd0, v_valid}, 128'd1);
    @(negedge clk);
    chk("s1_valid_fall", {127'd0, v_valid}, 128'd0);
    chk("s1_vec_count", {120'd0, vec_count}, 128'd1);

    // All-negative vector exercises the signed compare.
    run_vec(mk(-8, -1, -5, -1, -9, -7, -2, -3), -16'sd1, 3'd1, 0, 1'b1);
    @(negedge clk);
    chk("s2_vec_count", {120'd0, vec_count}, 128'd2);

    // Backpressure: both banks fill, 17th word waits.
    do_reset();
    v_ready = 1'b0;
    run_vec(mk(3, 9, -4, 9, 100, -100, 50, 2), 16'sd100, 3'd4, 0, 1'b1);
    run_vec(mk(-7, -7, -7, -7, -7, -7, -7, -7), -16'sd7, 3'd0, 0, 1'b1);
    chk("bp_s_ready_low", {127'd0, s_ready}, 128'd0);
    chk("bp_v_valid", {127'd0, v_valid}, 128'd1);
    s_valid = 1'b1;
    data_in = 16'sd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_word17_held", {127'd0, s_ready}, 128'd0);
    end
    v_ready = 1'b1;
    @(negedge clk);
    v_ready = 1'b0;
    #1;
    chk("bp_s_ready_back", {127'd0, s_ready}, 128'd1);
    chk("bp_vec_count", {120'd0, vec_count}, 128'd1);
    @(negedge clk);
    send(16'sd1); send(16'sd2); send(16'sd3); send(16'sd4);
    chk("bp_second_valid", {127'd0, v_valid}, 128'd1);
    v_ready = 1'b1;
    @(negedge clk);
    chk("bp_vec_count2", {120'd0, vec_count}, 128'd2);

    // Throttled input, then hold the vector under v_ready=0.
    do_reset();
    v_ready = 1'b0;
    run_vec(mk(5, -3, 12, 7, 12, 0, -20, 1), 16'sd12, 3'd2, 2, 1'b1);
    n = 0;
    while (!v_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("thr_v_valid", {127'd0, v_valid}, 128'd1);
    snap = v_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("thr_v_data_hold", v_data, snap);
    end
    v_ready = 1'b1;
    @(negedge clk);
    chk("thr_vec_count", {120'd0, vec_count}, 128'd1);

    // Reset mid-vector discards the partial words.
    do_reset();
    v_ready = 1'b1;
    send(16'sd1000); send(16'sd1); send(16'sd1); send(16'sd1); send(16'sd1);
    do_reset();
    run_vec(mk(0, -32768, 0, 0, 0, 0, 0, 32767), 16'sd32767, 3'd7, 0, 1'b1);
    @(negedge clk);
    chk("rm_vec_count", {120'd0, vec_count}, 128'd1);

    // 257 vectors back-to-back: vec_count wraps, s_ready never drops.
    do_reset();
    v_ready = 1'b1;
    watch_sready = 1'b1;
    for (int v = 0; v < 257; v++) begin
      p = v % 8;
      d = '0;
      for (int k = 0; k < 8; k++) d[k*16 +: 16] = (k == p) ? 16'(v) : 16'(-k);
      run_vec(d, (v == 0) ? 16'sd0 : 16'(v), (v == 0) ? 3'd0 : 3'(p), 0, 1'b1);
    end
    watch_sready = 1'b0;
    @(negedge clk);
    chk("wrap_vec_count", {120'd0, vec_count}, 128'd1);
    chk("wrap_no_sready_drop", 128'(sready_drops), 128'd0);

    @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
